// File: rtl/seg_scan_decoder_if.sv
// Scan-bus pins plus the decoded frame outputs of the seven-segment receiver.
// The master drives seg/ans and consumes the frame. The slave is the decoder.
interface seg_scan_decoder_if;
    logic [6:0]  seg;
    logic [3:0]  ans;
    logic [15:0] digits;
    logic        frame_valid;
    logic        seg_err;
    logic        link_lost;

    modport master (
        output seg,
        output ans,
        input  digits,
        input  frame_valid,
        input  seg_err,
        input  link_lost
    );

    modport slave (
        input  seg,
        input  ans,
        output digits,
        output frame_valid,
        output seg_err,
        output link_lost
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan receiver: deglitches digit dwells, decodes them, and publishes 4-digit frames.
// Capture lands STABLE_CYC cycles after a dwell appears at the pins and the frame one cycle later; no backpressure.
module seg_scan_decoder #(
    parameter int STABLE_CYC = 16,
    parameter int TIMEOUT    = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    seg_scan_decoder_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYC);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

    logic [6:0]    seg_r;
    logic [6:0]    seg_p;
    logic [3:0]    ans_r;
    logic [3:0]    ans_p;
    logic [CW-1:0] stab_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    seen;
    logic          err_acc;
    logic [3:0]    shadow [4];
    logic [15:0]   digits_q;
    logic          frame_valid_q;
    logic          seg_err_q;
    logic          link_lost_q;

    logic [3:0]    ans_act;
    logic [6:0]    seg_act;
    logic          ans_ok;
    logic [1:0]    pos;
    logic          same;
    logic          capture;
    logic          commit;
    logic [3:0]    code;
    logic          invalid;

    always_comb begin
        ans_act = ~ans_r;
        ans_ok  = 1'b0;
        pos     = 2'd0;
        case (ans_act)
            4'b0001: begin ans_ok = 1'b1; pos = 2'd0; end
            4'b0010: begin ans_ok = 1'b1; pos = 2'd1; end
            4'b0100: begin ans_ok = 1'b1; pos = 2'd2; end
            4'b1000: begin ans_ok = 1'b1; pos = 2'd3; end
            default: begin ans_ok = 1'b0; pos = 2'd0; end
        endcase
    end

    // Active-high segment set, bit 0 = a ... bit 6 = g; exact matches only.
    always_comb begin
        seg_act = ~seg_r;
        code    = 4'hF;
        invalid = 1'b0;
        case (seg_act)
            7'h3F:   code = 4'h0;
            7'h06:   code = 4'h1;
            7'h5B:   code = 4'h2;
            7'h4F:   code = 4'h3;
            7'h66:   code = 4'h4;
            7'h6D:   code = 4'h5;
            7'h7D:   code = 4'h6;
            7'h07:   code = 4'h7;
            7'h7F:   code = 4'h8;
            7'h6F:   code = 4'h9;
            7'h00:   code = 4'hA;
            default: begin code = 4'hF; invalid = 1'b1; end
        endcase
    end

    assign same    = (seg_r == seg_p) && (ans_r == ans_p);
    assign capture = ans_ok && same && (stab_cnt == STAB_MAX - CW'(1));
    assign commit  = (seen == 4'hF);

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_r         <= 7'h7F;
            seg_p         <= 7'h7F;
            ans_r         <= 4'hF;
            ans_p         <= 4'hF;
            stab_cnt      <= '0;
            tmo_cnt       <= '0;
            seen          <= 4'h0;
            err_acc       <= 1'b0;
            for (int i = 0; i < 4; i++) shadow[i] <= 4'hA;
            digits_q      <= 16'hAAAA;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            link_lost_q   <= 1'b0;
        end else begin
            seg_r <= bus.seg;
            ans_r <= bus.ans;
            seg_p <= seg_r;
            ans_p <= ans_r;

            // stab_cnt is the length of the current run of identical, single-anode samples.
            if (!ans_ok)
                stab_cnt <= '0;
            else if (!same)
                stab_cnt <= CW'(1);
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + CW'(1);

            if (capture)
                shadow[pos] <= code;

            frame_valid_q <= commit;
            if (commit) begin
                digits_q  <= {shadow[3], shadow[2], shadow[1], shadow[0]};
                seg_err_q <= err_acc;
                seen      <= 4'h0;
                err_acc   <= 1'b0;
            end else if (capture) begin
                seen[pos] <= 1'b1;
                err_acc   <= err_acc | invalid;
            end

            if (commit) begin
                tmo_cnt     <= '0;
                link_lost_q <= 1'b0;
            end else begin
                if (tmo_cnt != TMO_MAX)
                    tmo_cnt <= tmo_cnt + TW'(1);
                if (tmo_cnt >= TMO_MAX - TW'(1))
                    link_lost_q <= 1'b1;
            end
        end
    end

    assign bus.digits      = digits_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.link_lost   = link_lost_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized and directed scan-bus stimulus against a dwell-level reference model.
module tb_seg_scan_decoder;
    localparam int S = 16;
    localparam int T = 200;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    seg_scan_decoder_if bus();

    seg_scan_decoder #(.STABLE_CYC(S), .TIMEOUT(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    int ref_edge = 0;
    int fv_cnt = 0;
    int last_fv_edge = 0;
    int rise_edge = 0;
    logic prev_link_obs = 1'b0;
    logic link_at_fv = 1'b0;

    logic [3:0]  m_seen = 4'h0;
    logic        m_err  = 1'b0;
    logic [3:0]  m_shadow [4];
    logic [15:0] x_digits = 16'hAAAA;
    logic        x_fv = 1'b0;
    logic        x_err = 1'b0;
    logic        x_link = 1'b0;

    int         cap_edge [$];
    int         cap_pos  [$];
    logic [3:0] cap_code [$];
    logic       cap_bad  [$];

    logic [6:0] prev_seg = 7'h7F;
    logic [3:0] prev_ans = 4'hF;

    string dstr [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                         "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic logic [6:0] mask_of(input string s);
        logic [6:0] m;
        m = 7'h00;
        for (int i = 0; i < s.len(); i++) m = m | (7'd1 << (int'(s[i]) - 97));
        return m;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        return ~mask_of(dstr[d]);
    endfunction

    function automatic logic [3:0] ans_of(input int p);
        return 4'hF ^ (4'd1 << p);
    endfunction

    task automatic ref_decode(input logic [6:0] seg, output logic [3:0] code, output logic bad);
        code = 4'hF;
        bad  = 1'b1;
        if (seg == 7'h7F) begin
            code = 4'hA;
            bad  = 1'b0;
        end
        for (int d = 0; d < 10; d++) begin
            if (~seg == mask_of(dstr[d])) begin
                code = 4'(d);
                bad  = 1'b0;
            end
        end
    endtask

    // One clock edge of the reference: commit on a full frame, then apply any capture due now.
    task automatic model_edge();
        x_fv = 1'b0;
        if (!reset) begin
            m_seen = 4'h0;
            m_err  = 1'b0;
            for (int p = 0; p < 4; p++) m_shadow[p] = 4'hA;
            x_digits = 16'hAAAA;
            x_err    = 1'b0;
            x_link   = 1'b0;
            ref_edge = edge_n;
            cap_edge.delete(); cap_pos.delete(); cap_code.delete(); cap_bad.delete();
        end else begin
            if (m_seen == 4'hF) begin
                x_digits = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
                x_err    = m_err;
                x_fv     = 1'b1;
                x_link   = 1'b0;
                m_seen   = 4'h0;
                m_err    = 1'b0;
                ref_edge = edge_n;
            end
            while (cap_edge.size() > 0 && cap_edge[0] == edge_n) begin
                m_shadow[cap_pos[0]] = cap_code[0];
                m_seen[cap_pos[0]]   = 1'b1;
                m_err                = m_err | cap_bad[0];
                void'(cap_edge.pop_front()); void'(cap_pos.pop_front());
                void'(cap_code.pop_front()); void'(cap_bad.pop_front());
            end
            if (edge_n - ref_edge >= T) x_link = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        model_edge();
        @(negedge clk);
        check_eq("frame_valid", 32'(bus.frame_valid), 32'(x_fv));
        check_eq("digits", 32'(bus.digits), 32'(x_digits));
        check_eq("seg_err", 32'(bus.seg_err), 32'(x_err));
        check_eq("link_lost", 32'(bus.link_lost), 32'(x_link));
        if (bus.frame_valid) begin
            fv_cnt++;
            last_fv_edge = edge_n;
            link_at_fv = bus.link_lost;
        end
        if (bus.link_lost && !prev_link_obs) rise_edge = edge_n;
        prev_link_obs = bus.link_lost;
    endtask

    // Hold one pin pattern for len cycles; neighbouring dwells always differ so they never merge.
    task automatic dwell(input logic [6:0] seg, input logic [3:0] ans, input int len);
        logic [3:0] code;
        logic       bad;
        logic [3:0] act;
        int         p;
        if (seg == prev_seg && ans == prev_ans) seg = seg ^ 7'h01;
        act = ~ans;
        if (len >= S && act != 4'h0 && (act & (act - 4'd1)) == 4'h0) begin
            ref_decode(seg, code, bad);
            p = 0;
            for (int i = 0; i < 4; i++) if (act[i]) p = i;
            cap_edge.push_back(edge_n + 1 + S);
            cap_pos.push_back(p);
            cap_code.push_back(code);
            cap_bad.push_back(bad);
        end
        bus.seg  = seg;
        bus.ans  = ans;
        prev_seg = seg;
        prev_ans = ans;
        repeat (len) tick();
    endtask

    task automatic show(input int p, input logic [6:0] seg, input int len);
        dwell(seg, ans_of(p), len);
        dwell(7'h7F, 4'hF, 2);
    endtask

    task automatic do_reset(input int n);
        bus.seg  = 7'h7F;
        bus.ans  = 4'hF;
        prev_seg = 7'h7F;
        prev_ans = 4'hF;
        reset    = 1'b0;
        repeat (n) tick();
        reset    = 1'b1;
    endtask

    initial begin
        int d3_start;
        int fv_before;
        int next_pos;
        bus.seg = 7'h7F;
        bus.ans = 4'hF;
        for (int p = 0; p < 4; p++) m_shadow[p] = 4'hA;

        do_reset(3);
        check_eq("rst_digits", 32'(bus.digits), 32'h0000AAAA);
        check_eq("rst_fv", 32'(bus.frame_valid), 32'h0);
        check_eq("rst_err", 32'(bus.seg_err), 32'h0);
        check_eq("rst_link", 32'(bus.link_lost), 32'h0);

        // Normal scan d0..d3 = 4,3,2,1.
        show(0, seg_of(4), 100);
        show(1, seg_of(3), 100);
        show(2, seg_of(2), 100);
        d3_start  = edge_n + 1;
        fv_before = fv_cnt;
        show(3, seg_of(1), 100);
        check_eq("scan_digits", 32'(bus.digits), 32'h00001234);
        check_eq("scan_err", 32'(bus.seg_err), 32'h0);
        check_eq("scan_fv_count", 32'(fv_cnt - fv_before), 32'd1);
        check_eq("scan_latency", 32'(last_fv_edge - d3_start), 32'd17);

        // Deglitch: glitched and 15-cycle dwells never capture, 16 clean cycles do.
        fv_before = fv_cnt;
        repeat (5) begin
            dwell(seg_of(5), ans_of(0), 9);
            dwell(seg_of(5) ^ 7'h10, ans_of(0), 1);
        end
        dwell(seg_of(6), ans_of(1), 15);
        dwell(7'h7F, 4'hF, 2);
        show(1, seg_of(6), 16);
        show(2, seg_of(7), 16);
        show(3, seg_of(8), 16);
        check_eq("glitch_no_frame", 32'(fv_cnt - fv_before), 32'd0);
        show(0, seg_of(5), 16);
        check_eq("glitch_clean_frame", 32'(fv_cnt - fv_before), 32'd1);
        check_eq("glitch_digits", 32'(bus.digits), 32'h00008765);

        // Bad pattern on d2 (segments a+g only).
        show(0, seg_of(9), 20);
        show(1, seg_of(5), 20);
        show(2, ~7'h41, 20);
        show(3, seg_of(1), 20);
        check_eq("bad_digits", 32'(bus.digits), 32'h00001F59);
        check_eq("bad_err", 32'(bus.seg_err), 32'h1);
        for (int p = 0; p < 4; p++) show(p, seg_of(0), 20);
        check_eq("bad_recover_err", 32'(bus.seg_err), 32'h0);
        check_eq("bad_recover_digits", 32'(bus.digits), 32'h00000000);

        // Blank digit and overwrite of d1 before the frame completes.
        show(3, 7'h7F, 20);
        show(2, seg_of(6), 20);
        show(1, seg_of(7), 20);
        show(1, seg_of(8), 20);
        show(0, seg_of(0), 20);
        check_eq("blank_digits", 32'(bus.digits), 32'h0000A680);
        check_eq("blank_err", 32'(bus.seg_err), 32'h0);

        // Timeout after the last commit, cleared by the next frame.
        dwell(7'h7F, 4'hF, 260);
        check_eq("tmo_rise", 32'(rise_edge - last_fv_edge), 32'd200);
        check_eq("tmo_high", 32'(bus.link_lost), 32'h1);
        for (int p = 0; p < 4; p++) show(p, seg_of(p + 2), 20);
        check_eq("tmo_clear_at_fv", 32'(link_at_fv), 32'h0);

        // Reset mid-frame discards partial captures.
        show(0, seg_of(1), 20);
        show(1, seg_of(2), 20);
        do_reset(3);
        fv_before = fv_cnt;
        show(2, seg_of(3), 20);
        show(3, seg_of(4), 20);
        check_eq("rstmid_no_frame", 32'(fv_cnt - fv_before), 32'd0);
        check_eq("rstmid_digits", 32'(bus.digits), 32'h0000AAAA);
        check_eq("rstmid_err", 32'(bus.seg_err), 32'h0);
        check_eq("rstmid_link", 32'(bus.link_lost), 32'h0);

        // Randomized scan traffic.
        next_pos = 0;
        for (int k = 0; k < 300; k++) begin
            int         kind;
            int         p;
            int         len;
            logic [6:0] sg;
            logic [3:0] an;
            kind = $urandom_range(0, 15);
            p    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : next_pos;
            next_pos = (p + 1) % 4;
            an   = ans_of(p);
            sg   = seg_of($urandom_range(0, 9));
            len  = $urandom_range(S - 2, S + 24);
            if (kind == 9) sg = 7'h7F;
            else if (kind == 10) sg = 7'($urandom);
            else if (kind == 11) an = 4'($urandom_range(0, 15));
            else if (kind == 12) len = $urandom_range(1, S - 1);
            else if (kind == 13 && $urandom_range(0, 2) == 0) begin
                an  = 4'hF;
                sg  = 7'h7F;
                len = $urandom_range(T, T + 60);
            end
            dwell(sg, an, len);
            if ($urandom_range(0, 60) == 0) do_reset($urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
